// File: rtl/boot_pkg.sv
// Shared definitions for the boot/run/dump sequencer: state encoding,
// word size and the word-indexed address helper.
package boot_pkg;

  localparam int WORD_BYTES = 4;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_LOAD     = 3'd1;
  localparam state_t ST_RUN      = 3'd2;
  localparam state_t ST_DUMP_RD  = 3'd3;
  localparam state_t ST_DUMP_OUT = 3'd4;
  localparam state_t ST_DONE     = 3'd5;

  // Byte address of word idx above base; callers truncate to their address
  // width, which gives silent modulo-2^ADDR_W wrap.
  function automatic logic [63:0] word_addr(input logic [63:0] base,
                                            input logic [63:0] idx);
    return base + idx * 64'(WORD_BYTES);
  endfunction

endpackage

// File: rtl/boot_dump_stream.sv
// Read-and-hold streamer for the post-run data memory dump. The top FSM
// owns the DUMP_RD/DUMP_OUT sequencing; this block keeps the word index,
// forms the read address and holds each word stable until dump_ready.
module boot_dump_stream
  import boot_pkg::*;
#(
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned CNT_W      = 32,
  parameter logic [ADDR_W-1:0] DMEM_BASE = 'h1001_0000,
  parameter int unsigned DUMP_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_phase,
  input  logic              out_phase,
  input  logic [WORD_W-1:0] dmem_rdata,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] dump_data,
  output logic [ADDR_W-1:0] dump_addr,
  output logic              dump_valid,
  output logic              last
);

  logic [CNT_W-1:0]  idx;
  logic              fresh;
  logic [WORD_W-1:0] held;
  logic [ADDR_W-1:0] cur_addr;

  assign cur_addr = ADDR_W'(word_addr(64'(DMEM_BASE), 64'(idx)));

  // Index advances per accepted word and clears whenever no dump is active;
  // the read word is captured on the first DUMP_OUT cycle, when the
  // synchronous memory presents it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx   <= '0;
      fresh <= 1'b0;
      held  <= '0;
    end else begin
      fresh <= rd_phase;
      if (fresh) held <= dmem_rdata;
      if (!rd_phase && !out_phase) idx <= '0;
      else if (out_phase && dump_ready) idx <= idx + CNT_W'(1);
    end
  end

  // Memory data is live for one cycle after the read, then the held copy
  // keeps the word stable through any dump_ready stall.
  always_comb begin
    rd_addr    = rd_phase ? cur_addr : '0;
    dump_valid = out_phase;
    dump_addr  = out_phase ? cur_addr : '0;
    dump_data  = '0;
    if (out_phase) dump_data = fresh ? dmem_rdata : held;
    last       = (idx + CNT_W'(1)) == CNT_W'(DUMP_WORDS);
  end

endmodule

// File: rtl/mem_boot_ctrl.sv
// Boot/run/dump sequencer: streams a program into instruction memory,
// releases the core until halt or cycle budget, then dumps a data window.
//
//   state       | meaning
//   ------------+--------------------------------------------------------
//   ST_IDLE     | after reset, waiting for start
//   ST_LOAD     | accepting program words into instruction memory
//   ST_RUN      | core out of reset, data memory owned by the core
//   ST_DUMP_RD  | issue one data memory read for the current dump word
//   ST_DUMP_OUT | present the word on dump_* until dump_ready
//   ST_DONE     | sequence finished, results held until start
module mem_boot_ctrl
  import boot_pkg::*;
#(
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] IMEM_BASE = 'h0040_0000,
  parameter int unsigned IMEM_WORDS = 1024,
  parameter logic [ADDR_W-1:0] DMEM_BASE = 'h1001_0000,
  parameter int unsigned DUMP_WORDS = 256,
  parameter int unsigned MAX_CYCLES = 100000,
  parameter int unsigned CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] ld_data,
  input  logic              ld_valid,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              imem_wr_n,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  input  logic [ADDR_W-1:0] core_pc,
  output logic              core_rst,
  input  logic              core_halt,
  input  logic              core_dmem_rd,
  input  logic              core_dmem_wr,
  input  logic [ADDR_W-1:0] core_dmem_addr,
  input  logic [WORD_W-1:0] core_dmem_wdata,
  output logic              dmem_rd,
  output logic              dmem_wr_n,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [WORD_W-1:0] dmem_wdata,
  input  logic [WORD_W-1:0] dmem_rdata,
  output logic [WORD_W-1:0] dump_data,
  output logic [ADDR_W-1:0] dump_addr,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              overflow,
  output logic [CNT_W-1:0]  load_count,
  output logic [CNT_W-1:0]  run_cycles
);

  // With an empty dump window the run exits straight to DONE.
  localparam state_t ST_AFTER_RUN = (DUMP_WORDS == 0) ? ST_DONE : ST_DUMP_RD;

  state_t            state, state_nxt;
  logic              idle_like;
  logic              ld_fire;
  logic              ld_full;
  logic              budget_hit;
  logic              dump_last;
  logic [ADDR_W-1:0] rd_addr;

  assign idle_like  = (state == ST_IDLE) || (state == ST_DONE);
  assign ld_fire    = (state == ST_LOAD) && ld_valid;
  assign ld_full    = (load_count + CNT_W'(1)) == CNT_W'(IMEM_WORDS);
  assign budget_hit = run_cycles == CNT_W'(MAX_CYCLES - 1);

  // Next-state selection; start outside IDLE/DONE is ignored.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_nxt = ST_LOAD;
      ST_LOAD: begin
        if (ld_fire) begin
          if (ld_last)      state_nxt = ST_RUN;
          else if (ld_full) state_nxt = ST_DONE;
        end
      end
      ST_RUN:      if (core_halt || budget_hit) state_nxt = ST_AFTER_RUN;
      ST_DUMP_RD:  state_nxt = ST_DUMP_OUT;
      ST_DUMP_OUT: if (dump_ready) state_nxt = dump_last ? ST_DONE : ST_DUMP_RD;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // State, counters and sticky status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      load_count <= '0;
      run_cycles <= '0;
      timeout    <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (idle_like && start) begin
        load_count <= '0;
        run_cycles <= '0;
        timeout    <= 1'b0;
        overflow   <= 1'b0;
      end
      if (ld_fire) load_count <= load_count + CNT_W'(1);
      if (ld_fire && !ld_last && ld_full) overflow <= 1'b1;
      if (state == ST_RUN) begin
        run_cycles <= run_cycles + CNT_W'(1);
        if (budget_hit && !core_halt) timeout <= 1'b1;
      end
    end
  end

  // Memory-side muxing: loader owns imem in LOAD, core owns both memories
  // in RUN, dump streamer owns dmem reads in DUMP_RD.
  always_comb begin
    imem_wr_n  = 1'b1;
    imem_addr  = '0;
    imem_wdata = '0;
    dmem_rd    = 1'b0;
    dmem_wr_n  = 1'b1;
    dmem_addr  = '0;
    dmem_wdata = '0;
    case (state)
      ST_LOAD: begin
        imem_wr_n  = ~ld_valid;
        imem_addr  = ADDR_W'(word_addr(64'(IMEM_BASE), 64'(load_count)));
        imem_wdata = ld_data;
      end
      ST_RUN: begin
        imem_addr  = core_pc;
        dmem_rd    = core_dmem_rd;
        dmem_wr_n  = ~core_dmem_wr;
        dmem_addr  = core_dmem_addr;
        dmem_wdata = core_dmem_wdata;
      end
      ST_DUMP_RD: begin
        dmem_rd   = 1'b1;
        dmem_addr = rd_addr;
      end
      default: ;
    endcase
  end

  // Status and core control decoded straight from state.
  always_comb begin
    ld_ready = (state == ST_LOAD);
    core_rst = (state != ST_RUN);
    busy     = !idle_like;
    done     = (state == ST_DONE);
  end

  boot_dump_stream #(
    .WORD_W     (WORD_W),
    .ADDR_W     (ADDR_W),
    .CNT_W      (CNT_W),
    .DMEM_BASE  (DMEM_BASE),
    .DUMP_WORDS (DUMP_WORDS)
  ) u_dump (
    .clk        (clk),
    .rst        (rst),
    .rd_phase   (state == ST_DUMP_RD),
    .out_phase  (state == ST_DUMP_OUT),
    .dmem_rdata (dmem_rdata),
    .dump_ready (dump_ready),
    .rd_addr    (rd_addr),
    .dump_data  (dump_data),
    .dump_addr  (dump_addr),
    .dump_valid (dump_valid),
    .last       (dump_last)
  );

endmodule

// File: tb/tb_mem_boot_ctrl.sv
// Directed-plus-random bench for mem_boot_ctrl with a behavioural data
// memory and an expected-contents array for the dump window.
module tb_mem_boot_ctrl;

  localparam int IMW  = 8;
  localparam int DW   = 4;
  localparam int MAXC = 64;
  localparam logic [31:0] IBASE = 32'h0040_0000;
  localparam logic [31:0] DBASE = 32'h1001_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [31:0] ld_data = '0;
  logic ld_valid = 1'b0, ld_last = 1'b0, ld_ready;
  logic imem_wr_n;
  logic [31:0] imem_addr, imem_wdata;
  logic [31:0] core_pc = '0;
  logic core_rst;
  logic core_halt = 1'b0, core_dmem_rd = 1'b0, core_dmem_wr = 1'b0;
  logic [31:0] core_dmem_addr = '0, core_dmem_wdata = '0;
  logic dmem_rd, dmem_wr_n;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [31:0] dmem_rdata = '0;
  logic [31:0] dump_data, dump_addr;
  logic dump_valid;
  logic dump_ready = 1'b0;
  logic busy, done, timeout, overflow;
  logic [31:0] load_count, run_cycles;

  mem_boot_ctrl #(.IMEM_WORDS(IMW), .DUMP_WORDS(DW), .MAX_CYCLES(MAXC)) dut (
    .clk(clk), .rst(rst), .start(start),
    .ld_data(ld_data), .ld_valid(ld_valid), .ld_last(ld_last), .ld_ready(ld_ready),
    .imem_wr_n(imem_wr_n), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_pc(core_pc), .core_rst(core_rst), .core_halt(core_halt),
    .core_dmem_rd(core_dmem_rd), .core_dmem_wr(core_dmem_wr),
    .core_dmem_addr(core_dmem_addr), .core_dmem_wdata(core_dmem_wdata),
    .dmem_rd(dmem_rd), .dmem_wr_n(dmem_wr_n), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dump_data(dump_data), .dump_addr(dump_addr), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .busy(busy), .done(done), .timeout(timeout),
    .overflow(overflow), .load_count(load_count), .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural data memory for the dump window (4 words), 1-cycle read.
  logic [31:0] mem [DW];
  logic [31:0] init_words [DW];
  logic [31:0] exp_mem [DW];
  logic mem_load = 1'b0;
  logic [31:0] moff;
  logic in_win;
  int rd_pulses = 0;
  assign moff   = dmem_addr - DBASE;
  assign in_win = (moff < 32'(4 * DW)) && (moff[1:0] == 2'b00);

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < DW; i++) mem[i] <= init_words[i];
    end else if (!dmem_wr_n && in_win) begin
      mem[moff[3:2]] <= dmem_wdata;
    end
    if (dmem_rd) dmem_rdata <= in_win ? mem[moff[3:2]] : 32'hDEAD_BEEF;
    if (dmem_rd && core_rst) rd_pulses <= rd_pulses + 1;
  end

  logic [31:0] prog [16];

  task automatic reset_checks(input string pfx);
    check({pfx, "_ctl"}, {core_rst, imem_wr_n, dmem_wr_n, dmem_rd, ld_ready, dump_valid,
                          busy, done, timeout, overflow}, 10'b1110000000);
    check({pfx, "_cnt"}, {load_count, run_cycles}, '0);
    check({pfx, "_addr"}, {imem_addr, dmem_addr, dump_addr}, '0);
    check({pfx, "_data"}, {imem_wdata, dmem_wdata, dump_data}, '0);
  endtask

  // Start pulse from IDLE/DONE, also reseeding the data window contents.
  task automatic pulse_start();
    for (int i = 0; i < DW; i++) begin
      init_words[i] = $urandom;
      exp_mem[i] = init_words[i];
    end
    @(negedge clk); start = 1'b1; mem_load = 1'b1; #1;
    @(negedge clk); start = 1'b0; mem_load = 1'b0; #1;
    check("start_flags", {busy, done, timeout, overflow, ld_ready}, 5'b10001);
    check("start_cnt", {load_count, run_cycles}, '0);
  endtask

  // mode 0: continuous valid, 1: one on / two off, 2: random.
  task automatic load_prog(input int n, input bit with_last, input int mode);
    int k = 0;
    int cyc = 0;
    bit v;
    while (k < n && cyc < 200) begin
      @(negedge clk);
      case (mode)
        0: v = 1'b1;
        1: v = (cyc % 3) == 0;
        default: v = 1'($urandom_range(0, 1));
      endcase
      ld_valid = v;
      ld_data  = prog[k];
      ld_last  = with_last && (k == n - 1);
      #1;
      if (k < IMW) begin
        check("ld_ready", ld_ready, 1'b1);
        check("ld_count", load_count, 32'(k));
        check("ld_wr_n", imem_wr_n, !v);
        if (v) begin
          check("ld_addr", imem_addr, IBASE + 32'(4 * k));
          check("ld_wdata", imem_wdata, prog[k]);
        end
      end else begin
        check("ovf_state", {ld_ready, imem_wr_n, overflow, done, core_rst, busy}, 6'b011110);
        check("ovf_count", load_count, 32'(IMW));
      end
      if (v) k++;
      cyc++;
    end
    check("ld_bound", cyc < 200, 1'b1);
    @(negedge clk);
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  // Run phase: halt_at is the RUN cycle with core_halt high (0 = never).
  // Entered at the negedge of the first RUN cycle, so the first cycle is
  // observed without waiting; load_prog already advanced one edge.
  task automatic run_core(input int halt_at, input int n_words);
    int exit_c;
    bit exp_to;
    bit w, r;
    logic [31:0] a, d;
    int widx;
    exit_c = (halt_at != 0 && halt_at <= MAXC) ? halt_at : MAXC;
    exp_to = !(halt_at != 0 && halt_at <= MAXC);
    for (int c = 1; c <= exit_c; c++) begin
      if (c > 1) @(negedge clk);
      w = ($urandom_range(0, 3) == 0);
      r = 1'($urandom_range(0, 1));
      widx = $urandom_range(0, DW - 1);
      a = DBASE + 32'(4 * widx);
      d = $urandom;
      core_halt = (c == halt_at);
      core_pc = $urandom;
      core_dmem_wr = w; core_dmem_rd = r; core_dmem_addr = a; core_dmem_wdata = d;
      start = (c == 3);
      #1;
      check("run_core_rst", {core_rst, busy}, 2'b01);
      check("run_pc", imem_addr, core_pc);
      check("run_dmem", {dmem_wr_n, dmem_rd, dmem_addr, dmem_wdata}, {!w, r, a, d});
      check("run_cyc", run_cycles, 32'(c - 1));
      if (w) exp_mem[widx] = d;
    end
    @(negedge clk);
    core_halt = 1'b0; core_dmem_wr = 1'b0; core_dmem_rd = 1'b0; start = 1'b0;
    #1;
    check("run_exit_rst", core_rst, 1'b1);
    check("run_total", run_cycles, 32'(exit_c));
    check("run_timeout", timeout, exp_to);
    check("run_loadcnt", load_count, 32'(n_words));
  endtask

  // Dump phase; core strobes are driven with junk to show they are ignored.
  task automatic dump_all(input int stall_word, input int stall_len);
    int rd_base;
    int cyc;
    int stall;
    logic [31:0] ea;
    rd_base = rd_pulses;
    for (int i = 0; i < DW; i++) begin
      cyc = 0;
      do begin
        @(negedge clk);
        dump_ready = 1'b0;
        core_dmem_wr = 1'b1; core_dmem_rd = 1'b1;
        core_dmem_addr = DBASE + 32'(4 * $urandom_range(0, DW - 1));
        core_dmem_wdata = $urandom;
        #1;
        cyc++;
      end while (!dump_valid && cyc < 10);
      check("dump_valid", dump_valid, 1'b1);
      ea = DBASE + 32'(4 * i);
      check("dump_addr", dump_addr, ea);
      check("dump_data", dump_data, exp_mem[i]);
      stall = (i == stall_word) ? stall_len : $urandom_range(0, 2);
      for (int s = 0; s < stall; s++) begin
        @(negedge clk); #1;
        check("stall_hold", {dump_valid, dmem_rd, dump_addr, dump_data}, {2'b10, ea, exp_mem[i]});
      end
      @(negedge clk); dump_ready = 1'b1; #1;
      check("hs_hold", {dump_valid, dump_addr, dump_data}, {1'b1, ea, exp_mem[i]});
    end
    @(negedge clk);
    dump_ready = 1'b0; core_dmem_wr = 1'b0; core_dmem_rd = 1'b0;
    #1;
    check("done_flags", {done, busy, dump_valid, core_rst}, 4'b1001);
    check("dump_reads", rd_pulses - rd_base, DW);
  endtask

  task automatic full_run(input int n, input int mode, input int halt_at,
                          input int stall_word, input int stall_len);
    for (int i = 0; i < n; i++) prog[i] = $urandom;
    pulse_start();
    load_prog(n, 1'b1, mode);
    run_core(halt_at, n);
    dump_all(stall_word, stall_len);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    ld_data = $urandom; core_pc = $urandom; core_dmem_addr = $urandom;
    repeat (3) @(negedge clk);
    #1;
    reset_checks("reset");
    @(negedge clk); rst = 1'b0; #1;
    reset_checks("idle");

    // 4-word program, continuous valid, halt after 50 cycles, stall on word 2.
    for (int i = 0; i < 4; i++) prog[i] = 32'h0000_0013 + 32'(i << 20);
    pulse_start();
    load_prog(4, 1'b1, 0);
    run_core(50, 4);
    dump_all(2, 5);

    // Gapped loading, halt on the last budget cycle: halt wins.
    full_run($urandom_range(1, IMW), 1, MAXC, -1, 0);
    // No halt: budget expires.
    full_run($urandom_range(1, IMW), 2, 0, -1, 0);
    // Random runs, some past the budget.
    for (int t = 0; t < 3; t++)
      full_run($urandom_range(1, IMW), $urandom_range(0, 2), $urandom_range(1, 80),
               $urandom_range(0, DW - 1), $urandom_range(0, 4));

    // Program longer than the instruction memory.
    for (int i = 0; i < 10; i++) prog[i] = $urandom;
    pulse_start();
    load_prog(10, 1'b0, 0);
    repeat (3) begin
      @(negedge clk); #1;
      check("ovf_hold", {core_rst, done, overflow, busy}, 4'b1110);
      check("ovf_run", run_cycles, '0);
    end

    // Reset in the middle of a dump.
    prog[0] = $urandom; prog[1] = $urandom;
    pulse_start();
    load_prog(2, 1'b1, 2);
    run_core(5, 2);
    cyc = 0;
    do begin @(negedge clk); #1; cyc++; end while (!dump_valid && cyc < 10);
    check("pre_rst_valid", dump_valid, 1'b1);
    @(negedge clk); rst = 1'b1; #1;
    reset_checks("mid_dump_rst");
    @(negedge clk); rst = 1'b0; dump_ready = 1'b1;
    repeat (4) begin
      @(negedge clk); #1;
      check("post_rst_quiet", {dump_valid, busy, dmem_rd}, 3'b000);
    end
    dump_ready = 1'b0;

    // Recovery after reset.
    full_run($urandom_range(1, IMW), 2, $urandom_range(1, 40), -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
